// File: rtl/osc_scan_pkg.sv
// Shared types, default parameters and the index search for the oscillator scan controller.
package osc_scan_pkg;

  localparam int unsigned DefNOsc      = 4;
  localparam int unsigned DefCntW      = 16;
  localparam int unsigned DefWinW      = 16;
  localparam int unsigned DefSettleCyc = 4;
  // Widest mask the index search supports.
  localparam int unsigned MaxOsc       = 8;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StGate,
    StReport,
    StDone
  } osc_scan_state_t;

  // Lowest set bit of mask at an index >= from, or -1 when there is none.
  function automatic int next_set_bit(input logic [MaxOsc-1:0] mask, input int from);
    int res;
    res = -1;
    for (int i = MaxOsc - 1; i >= 0; i--) begin
      if (mask[i] && (i >= from)) res = i;
    end
    return res;
  endfunction

endpackage

// File: rtl/osc_edge_sync.sv
// Two-flop synchronizer for the asynchronous oscillator input plus a rising-edge pulse.
module osc_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic sync1_q, sync2_q, prev_q;

  // Synchronizer chain; only rst clears it, never the scan state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/osc_scan_ctrl.sv
// Scans the enabled oscillators one at a time: settle, count edges over a gate window, report.
module osc_scan_ctrl
  import osc_scan_pkg::*;
#(
  parameter int unsigned N_OSC      = DefNOsc,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned WIN_W      = DefWinW,
  parameter int unsigned SETTLE_CYC = DefSettleCyc
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [WIN_W-1:0]         window,
  input  logic [N_OSC-1:0]         osc_mask,
  input  logic                     osc_in,
  output logic [$clog2(N_OSC)-1:0] osc_sel,
  output logic                     osc_run,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(N_OSC)-1:0] res_idx,
  output logic [CNT_W-1:0]         res_count,
  output logic                     res_ovf,
  output logic                     done
);

  localparam int unsigned SelW = $clog2(N_OSC);

  osc_scan_state_t state_q, state_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic [SelW-1:0]  idx_q, idx_d;
  logic [N_OSC-1:0] mask_q, mask_d;
  logic [WIN_W-1:0] win_q, win_d;
  // One down-counter serves both the settle delay and the gate window.
  logic [WIN_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             rise;
  int               first_idx, next_idx;

  osc_edge_sync u_edge_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (osc_in),
    .rise (rise)
  );

  // Next-state: sequencing through the mask, timers and the saturating edge counter.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    win_d     = win_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    first_idx = next_set_bit(MaxOsc'(osc_mask), 0);
    next_idx  = next_set_bit(MaxOsc'(mask_q), int'(sel_q) + 1);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mask_d = osc_mask;
          win_d  = window;
          if (first_idx >= 0) begin
            state_d = StSettle;
            sel_d   = SelW'(first_idx);
            tmr_d   = WIN_W'(SETTLE_CYC - 1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (tmr_q == '0) begin
          state_d = StGate;
          // A zero window still opens the gate for one cycle.
          tmr_d   = (win_q == '0) ? '0 : win_q - 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StGate: begin
        if (rise) begin
          if (cnt_q == '1) ovf_d = 1'b1;
          else             cnt_d = cnt_q + 1'b1;
        end
        if (tmr_q == '0) begin
          state_d = StReport;
          idx_d   = sel_q;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      StReport: begin
        if (res_ready) begin
          if (next_idx >= 0) begin
            state_d = StSettle;
            sel_d   = SelW'(next_idx);
            tmr_d   = WIN_W'(SETTLE_CYC - 1);
          end else begin
            state_d = StDone;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      sel_q   <= '0;
      idx_q   <= '0;
      mask_q  <= '0;
      win_q   <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      win_q   <= win_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  // Outputs decode directly from registered state so they are glitch-free.
  always_comb begin
    busy      = (state_q == StSettle) || (state_q == StGate) || (state_q == StReport);
    osc_run   = busy;
    res_valid = (state_q == StReport);
    done      = (state_q == StDone);
    osc_sel   = sel_q;
    res_idx   = idx_q;
    res_count = cnt_q;
    res_ovf   = ovf_q;
  end

endmodule

// File: tb/tb_osc_scan_ctrl.sv
// Self-checking bench: a timeline model predicts every output cycle by cycle.
module tb_osc_scan_ctrl;

  localparam int NOsc   = 4;
  localparam int CntW   = 4;
  localparam int WinW   = 16;
  localparam int Settle = 4;
  localparam int CntMax = (1 << CntW) - 1;
  localparam int MaxCyc = 8192;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic [WinW-1:0] window = '0;
  logic [NOsc-1:0] osc_mask = '0;
  logic            osc_in = 1'b0;
  logic [1:0]      osc_sel;
  logic            osc_run, busy, res_valid, done, res_ovf;
  logic            res_ready = 1'b1;
  logic [1:0]      res_idx;
  logic [CntW-1:0] res_count;

  osc_scan_ctrl #(
    .N_OSC      (NOsc),
    .CNT_W      (CntW),
    .WIN_W      (WinW),
    .SETTLE_CYC (Settle)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .window    (window),
    .osc_mask  (osc_mask),
    .osc_in    (osc_in),
    .osc_sel   (osc_sel),
    .osc_run   (osc_run),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_idx   (res_idx),
    .res_count (res_count),
    .res_ovf   (res_ovf),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_err = 0;

  // Scan plan: each result j occupies cycles [s_j, h_j]; gate is [g0_j, r_j-1].
  bit plan_active = 0;
  int p_e, p_n, p_done;
  int p_idx[4], p_g0[4], p_r[4], p_h[4];
  int d_arr[4];
  int osc_period = 0;
  bit chk_en = 0;
  bit rise_at[MaxCyc];

  int hs_cyc[$], hs_idx[$], hs_cnt[$], hs_ovf[$], done_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic build_plan(input int e, input logic [3:0] mask, input int win);
    int s, w;
    s    = e;
    w    = (win == 0) ? 1 : win;
    p_e  = e;
    p_n  = 0;
    for (int i = 0; i < NOsc; i++) begin
      if (mask[i]) begin
        p_idx[p_n] = i;
        p_g0[p_n]  = s + Settle;
        p_r[p_n]   = p_g0[p_n] + w;
        p_h[p_n]   = p_r[p_n] + d_arr[p_n];
        s          = p_h[p_n] + 1;
        p_n++;
      end
    end
    p_done      = (p_n == 0) ? e : p_h[p_n-1] + 1;
    plan_active = 1;
  endtask

  // Rising edges first sampled at edge e reach the counter in cycle e+1.
  function automatic int model_raw(input int g0, input int r);
    int n;
    n = 0;
    for (int e = g0 - 1; e <= r - 2; e++) if (e >= 0 && rise_at[e]) n++;
    return n;
  endfunction

  // Oscillator, ready policy and handshake log, all driven on the falling edge.
  initial begin : drive_loop
    bit rdy;
    forever begin
      @(negedge clk);
      osc_in = (osc_period > 0) && ((cyc % osc_period) >= osc_period / 2);
      rdy = 1'b1;
      if (plan_active) begin
        for (int j = 0; j < p_n; j++) if (cyc >= p_r[j] && cyc < p_h[j]) rdy = 1'b0;
      end
      res_ready = rdy;
      #1;
      if (res_valid && res_ready) begin
        hs_cyc.push_back(cyc);
        hs_idx.push_back(int'(res_idx));
        hs_cnt.push_back(int'(res_count));
        hs_ovf.push_back(int'(res_ovf));
      end
    end
  end

  // Per-cycle comparison against the timeline model.
  initial begin : compare_loop
    bit osc_prev;
    int s, seg, raw;
    bit e_busy, e_valid, e_done;
    osc_prev = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (cyc < MaxCyc) rise_at[cyc] = osc_in && !osc_prev;
      osc_prev = osc_in;
      if (chk_en) begin
        seg    = -1;
        e_done = 1'b0;
        if (plan_active && cyc >= p_e) begin
          e_done = (cyc == p_done);
          s = p_e;
          for (int j = 0; j < p_n; j++) begin
            if (cyc >= s && cyc <= p_h[j]) seg = j;
            s = p_h[j] + 1;
          end
        end
        e_busy  = (seg >= 0);
        e_valid = e_busy && (cyc >= p_r[seg]);
        check("busy", int'(busy), int'(e_busy));
        check("osc_run", int'(osc_run), int'(e_busy));
        check("res_valid", int'(res_valid), int'(e_valid));
        check("done", int'(done), int'(e_done));
        if (e_busy) check("osc_sel", int'(osc_sel), p_idx[seg]);
        if (e_valid) begin
          raw = model_raw(p_g0[seg], p_r[seg]);
          check("res_idx", int'(res_idx), p_idx[seg]);
          check("res_count", int'(res_count), (raw > CntMax) ? CntMax : raw);
          check("res_ovf", int'(res_ovf), int'(raw > CntMax));
        end
        if (done) done_q.push_back(cyc);
      end
    end
  end

  task automatic clear_logs();
    hs_cyc.delete(); hs_idx.delete(); hs_cnt.delete(); hs_ovf.delete(); done_q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    plan_active = 0;
    @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_osc_run", int'(osc_run), 0);
    check("rst_valid", int'(res_valid), 0);
    check("rst_done", int'(done), 0);
    check("rst_osc_sel", int'(osc_sel), 0);
    check("rst_idx", int'(res_idx), 0);
    check("rst_count", int'(res_count), 0);
    check("rst_ovf", int'(res_ovf), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_scan(input logic [3:0] mask, input int win);
    @(negedge clk);
    clear_logs();
    build_plan(cyc + 1, mask, win);
    osc_mask = mask;
    window   = WinW'(win);
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    // Later input changes must not affect the running scan.
    osc_mask = ~mask;
    window   = 16'd3;
  endtask

  task automatic wait_scan_end();
    while (cyc < p_done + 3) @(negedge clk);
  endtask

  function automatic int q_at(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin : main
    int e0;
    d_arr = '{0, 0, 0, 0};
    repeat (3) @(negedge clk);
    do_reset();
    chk_en = 1;

    // Single oscillator, period 10 over a 100-cycle window.
    osc_period = 10;
    run_scan(4'b0100, 100);
    wait_scan_end();
    check("single_hs_count", hs_cyc.size(), 1);
    check("single_idx", q_at(hs_idx, 0), 2);
    check("single_count_10pm1", int'(q_at(hs_cnt, 0) >= 9 && q_at(hs_cnt, 0) <= 11), 1);
    check("single_ovf", q_at(hs_ovf, 0), 0);
    check("single_done_after_hs", q_at(done_q, 0), q_at(hs_cyc, 0) + 1);

    // Reset in the middle of a gate window.
    run_scan(4'b0001, 40);
    while (cyc < p_g0[0] + 10) @(negedge clk);
    clear_logs();
    do_reset();
    repeat (80) @(negedge clk);
    check("rstgate_no_valid", hs_cyc.size(), 0);
    check("rstgate_no_done", done_q.size(), 0);

    // Full scan with a 20-cycle stall on the second result.
    osc_period = 6;
    d_arr = '{0, 20, 0, 0};
    run_scan(4'b1011, 20);
    wait_scan_end();
    check("full_hs_count", hs_cyc.size(), 3);
    check("full_idx0", q_at(hs_idx, 0), 0);
    check("full_idx1", q_at(hs_idx, 1), 1);
    check("full_idx2", q_at(hs_idx, 2), 3);
    check("full_stall_gap", q_at(hs_cyc, 1) - q_at(hs_cyc, 0), 45);
    check("full_gap2", q_at(hs_cyc, 2) - q_at(hs_cyc, 1), 25);
    check("full_done_count", done_q.size(), 1);
    d_arr = '{0, 0, 0, 0};

    // Saturation: period 4 over 200 cycles overflows a 4-bit counter.
    osc_period = 4;
    run_scan(4'b0001, 200);
    wait_scan_end();
    check("sat_count", q_at(hs_cnt, 0), 15);
    check("sat_ovf", q_at(hs_ovf, 0), 1);

    // Empty mask: done on the cycle after start, nothing else.
    osc_period = 6;
    run_scan(4'b0000, 10);
    e0 = p_e;
    wait_scan_end();
    check("empty_done_cycle", q_at(done_q, 0), e0);
    check("empty_hs_count", hs_cyc.size(), 0);

    // Zero window behaves as a one-cycle gate.
    run_scan(4'b0001, 0);
    e0 = p_e;
    wait_scan_end();
    check("win0_valid_cycle", q_at(hs_cyc, 0), e0 + Settle + 1);

    // A start pulse during a scan is ignored.
    run_scan(4'b0011, 10);
    while (cyc < p_e + 8) @(negedge clk);
    osc_mask = 4'b1100;
    window   = 16'd2;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    wait_scan_end();
    check("busy_start_hs_count", hs_cyc.size(), 2);
    check("busy_start_idx0", q_at(hs_idx, 0), 0);
    check("busy_start_idx1", q_at(hs_idx, 1), 1);
    check("busy_start_done", done_q.size(), 1);

    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/osc_scan_ctrl.md
# osc_scan_ctrl

Measurement scheduler for the on-chip analog oscillators. It shares one digital edge counter between up to N_OSC oscillators. Each enabled oscillator is selected in turn through the analog mux, given time to settle, and its rising edges are counted over a programmable gate window. Each count is handed to the downstream readout logic through a valid/ready handshake.

## Interface
- N_OSC, 4: number of oscillators (mux inputs), 2..8
- CNT_W, 16: result counter width
- WIN_W, 16: gate-window length width, in clk cycles
- SETTLE_CYC, 4: cycles between a mux switch and gate open
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse; begins a scan (ignored while busy)
- window  in  WIN_W  gate length in clk cycles, latched on start
- osc_mask  in  N_OSC  per-oscillator enable, latched on start
- osc_in  in  1  muxed oscillator output, asynchronous to clk
- osc_sel  out  $clog2(N_OSC)  analog mux select
- osc_run  out  1  oscillator enable, high while the selected oscillator is needed
- busy  out  1  high from the cycle after start until done
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts the result
- res_idx  out  $clog2(N_OSC)  oscillator index of the result
- res_count  out  CNT_W  rising edges counted in the window
- res_ovf  out  1  count saturated
- done  out  1  one-cycle pulse at scan end

## Operation
- FSM states: IDLE, SETTLE, GATE, REPORT, DONE.
- IDLE → SETTLE on start when the latched mask ≠ 0.
  - osc_sel is set to the lowest set mask bit.
  - osc_run is set to 1.
  - The settle counter is loaded.
- IDLE → DONE on start when the mask = 0.
- SETTLE lasts SETTLE_CYC cycles. The counter is cleared and res_ovf is cleared. Then → GATE.
- GATE lasts max(window,1) cycles; window = 0 is treated as 1.
  - The counter increments on each synchronized rising edge detected during a GATE cycle.
  - The counter saturates at 2^CNT_W−1 and sets res_ovf.
  - When the window ends → REPORT.
- REPORT holds res_valid = 1 with stable res_idx, res_count and res_ovf until res_ready = 1.
  - On acceptance, if a higher set mask bit exists → SETTLE with osc_sel set to that index.
  - Otherwise → DONE.
- DONE lasts 1 cycle with done = 1, osc_run = 0 and busy = 0 the following cycle. Then → IDLE.
- osc_in passes through a 2-flop synchronizer plus an edge register; this gives a 3-cycle detect latency.
  - The synchronizer is never reset-gated by state; only rst clears it.
  - Edges still in the pipeline when GATE closes are discarded.
- Measurable oscillator frequency is < clk/2; above that, counts alias. This is not detected.
- start pulses while busy are ignored. window and osc_mask changes after start have no effect until the next scan.

## Timing
- Reset values:
  - state IDLE
  - osc_sel 0, osc_run 0, busy 0
  - res_valid 0, res_idx 0, res_count 0, res_ovf 0
  - done 0
  - synchronizer flops 0
- start sampled in cycle T (mask ≠ 0): busy, osc_run and osc_sel are valid at T+1. SETTLE spans T+1..T+SETTLE_CYC.
- GATE spans W cycles. res_valid rises the cycle after the last GATE cycle.
- A res_valid/res_ready handshake completes in the cycle both are high. The next SETTLE starts the following cycle. res_valid drops that cycle.
- res_ready held high: per-oscillator period = SETTLE_CYC + W + 1 cycles.
- Mask = 0: done pulses at T+1; busy stays low throughout.
- rst asserted in any state: all outputs return to reset values on the next edge; any pending result is lost.
- Simultaneous start and rst: rst wins.

## Structure
- Package osc_scan_pkg holds:
  - the state enum (osc_scan_state_t)
  - default parameter constants
  - the find-next-set-bit function used for the index search
- One sub-module, osc_edge_sync: 2-flop synchronizer plus rising-edge pulse, with clk and rst.
- The FSM, counters and output registers live in osc_scan_ctrl.

## Test plan
- Reset mid-GATE:
  - Stimulus: rst for 1 cycle during GATE.
  - Required response: next cycle all outputs are at reset values, state is IDLE, and no res_valid or done follows.
- Single oscillator:
  - Stimulus: mask=4'b0100, window=100, osc_in toggling every 5 clk (period 10), res_ready=1.
  - Required response: res_idx=2, res_count=10±1, res_ovf=0, done 1 cycle after acceptance.
- Full scan with backpressure:
  - Stimulus: mask=4'b1011, res_ready held low 20 cycles on the second result.
  - Required response: results in index order 0,1,3; res_valid and data stable while stalled; exactly three handshakes, then done.
- Saturation:
  - Stimulus: CNT_W=4, window=200, osc period 4.
  - Required response: res_count=15, res_ovf=1.
- Empty and degenerate inputs:
  - Stimulus: mask=0, start.
  - Required response: done at T+1, busy never high, no res_valid.
  - Stimulus: window=0.
  - Required response: GATE lasts exactly 1 cycle.
- start while busy:
  - Stimulus: second start pulse mid-scan with a different mask.
  - Required response: ignored; the original scan completes unchanged.
